// File: rtl/seq_alu_pkg.sv
// Shared opcode/state enums and constants for seq_alu.
// SEQ_ALU_DIV_EN adds the DIV/FIX states and routes op 15 to the divider.
package alu_pkg;
    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_SLTU  = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOR   = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MFHI  = 4'd11,
        OP_MFLO  = 4'd12,
        OP_MULT  = 4'd13,
        OP_MULTU = 4'd14,
        OP_DIV   = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef SEQ_ALU_DIV_EN
        ,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
`endif
    } state_e;

    // Ops that hand off to the iterative datapath instead of finishing in one cycle.
    function automatic logic is_muldiv(opcode_e op);
`ifdef SEQ_ALU_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction
endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle of seq_alu; master drives requests, slave is the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    // A request transfers on a rising edge with in_valid && in_ready; requests seen
    // while in_ready is low are dropped. out_valid is a one-cycle pulse, no backpressure.
    logic                     in_valid;
    logic                     in_ready;
    logic [alu_pkg::OP_W-1:0] op;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic                     out_valid;
    logic [WIDTH-1:0]         result;
    logic [WIDTH-1:0]         hi;
    logic [WIDTH-1:0]         lo;
    logic                     zero;
    logic                     overflow;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, hi, lo, zero, overflow
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, hi, lo, zero, overflow
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply (shift-add, one bit per cycle) and optional restoring divider.
// The divider and its DIV/FIX states exist only with SEQ_ALU_DIV_EN defined.
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  opcode_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output state_e           state_o,
    output logic             fin_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             ovf_o
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opd_q;
    logic             sgn_q;
    logic             last;

    logic [WIDTH:0]   m_add;
    logic [WIDTH:0]   m_sum;
    logic [WIDTH:0]   m_acc_d;
    logic [WIDTH-1:0] m_lo_d;

    assign last    = (cnt_q == LAST);
    assign state_o = state_q;

    // Signed multiply: the multiplier MSB carries weight -2^(W-1), so the last step subtracts.
    always_comb begin
        m_add = sgn_q ? {opd_q[WIDTH-1], opd_q} : {1'b0, opd_q};
        if (!lo_q[0]) begin
            m_sum = acc_q;
        end else if (sgn_q && last) begin
            m_sum = acc_q - m_add;
        end else begin
            m_sum = acc_q + m_add;
        end
        m_acc_d = {sgn_q & m_sum[WIDTH], m_sum[WIDTH:1]};
        m_lo_d  = {m_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    logic             qneg_q;
    logic             rneg_q;
    logic             dz_q;
    logic             dovf_q;
    logic [WIDTH:0]   d_sh;
    logic [WIDTH:0]   d_diff;
    logic [WIDTH:0]   d_acc_d;
    logic [WIDTH-1:0] d_lo_d;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        d_sh    = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        d_diff  = d_sh - {1'b0, opd_q};
        d_acc_d = d_diff[WIDTH] ? d_sh : d_diff;
        d_lo_d  = {lo_q[WIDTH-2:0], ~d_diff[WIDTH]};
        q_fix   = qneg_q ? -lo_q : lo_q;
        r_fix   = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        a_mag   = a_i[WIDTH-1] ? -a_i : a_i;
        b_mag   = b_i[WIDTH-1] ? -b_i : b_i;
    end
`endif

    always_comb begin
        fin_o = 1'b0;
        hi_o  = m_acc_d[WIDTH-1:0];
        lo_o  = m_lo_d;
        ovf_o = 1'b0;
        if ((state_q == S_MUL) && last) begin
            fin_o = 1'b1;
        end
`ifdef SEQ_ALU_DIV_EN
        // A zero divisor leaves the remainder equal to a; only the quotient needs forcing.
        if (state_q == S_FIX) begin
            fin_o = 1'b1;
            hi_o  = r_fix;
            lo_o  = dz_q ? '1 : q_fix;
            ovf_o = dovf_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            sgn_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dovf_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cnt_q <= '0;
                        acc_q <= '0;
`ifdef SEQ_ALU_DIV_EN
                        if (op_i == OP_DIV) begin
                            state_q <= S_DIV;
                            lo_q    <= a_mag;
                            opd_q   <= b_mag;
                            qneg_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                            rneg_q  <= a_i[WIDTH-1];
                            dz_q    <= (b_i == '0);
                            dovf_q  <= (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
                        end else
`endif
                        begin
                            state_q <= S_MUL;
                            lo_q    <= b_i;
                            opd_q   <= a_i;
                            sgn_q   <= (op_i == OP_MULT);
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= m_acc_d;
                    lo_q  <= m_lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state_q <= S_IDLE;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    acc_q <= d_acc_d;
                    lo_q  <= d_lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Sequential MIPS-style ALU: single-cycle ops here, MULT/MULTU/DIV in seq_alu_muldiv.
// SEQ_ALU_DIV_EN enables the divider; without it op 15 returns 0 with overflow set.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    opcode_e          op;
    logic             accept;
    logic             single;
    state_e           md_state;
    logic             md_fin;
    logic             md_ovf;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    assign op           = opcode_e'(bus.op);
    assign bus.in_ready = (md_state == S_IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign single       = !is_muldiv(op);

    seq_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && !single),
        .op_i    (op),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .state_o (md_state),
        .fin_o   (md_fin),
        .hi_o    (md_hi),
        .lo_o    (md_lo),
        .ovf_o   (md_ovf)
    );

    assign sum = bus.a + bus.b;
    assign dif = bus.a - bus.b;
    assign sh  = bus.b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SLL:  alu_res = bus.a << sh;
            OP_SRL:  alu_res = bus.a >> sh;
            OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> sh);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
`ifndef SEQ_ALU_DIV_EN
            OP_DIV:  alu_ovf = 1'b1;
`endif
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // accept needs IDLE and md_fin needs a busy state, so the two branches never collide.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (accept && single) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
        end else if (md_fin) begin
            out_valid_d = 1'b1;
            result_d    = md_lo;
            zero_d      = (md_lo == '0);
            ovf_d       = md_ovf;
            hi_d        = md_hi;
            lo_d        = md_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: the driver queues hand-computed results, a monitor checks
// every out_valid pulse against the queue, including the cycle it is expected on.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int EW = 3 * W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [W-1:0]  m_hi   = '0;
  logic [W-1:0]  m_lo   = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a negedge; leaves in_valid asserted so back-to-back issues work.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic ovf, input int lat, input bit push);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_issue", W'(bus.in_ready), W'(1));
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    if (push) begin
      exp_q.push_back({res, (res == '0), ovf, m_hi, m_lo});
      exp_cyc_q.push_back(cyc + lat);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", W'(exp_q.size()), W'(0));
  endtask

  logic [EW-1:0] mon_e;
  int            mon_c;
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_out_valid: actual result %0h required no output (cycle %0d)", bus.result, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("result",   bus.result,       mon_e[3*W+1:2*W+2]);
        check("zero",     W'(bus.zero),     W'(mon_e[2*W+1]));
        check("overflow", W'(bus.overflow), W'(mon_e[2*W]));
        check("hi",       bus.hi,           mon_e[2*W-1:W]);
        check("lo",       bus.lo,           mon_e[W-1:0]);
        check("latency",  W'(cyc),          W'(mon_c));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  int           busy_ready;
  int           busy_hilo;
  logic [W-1:0] old_hi;
  logic [W-1:0] old_lo;

  initial begin
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.a        = '0;
    bus.b        = '0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_result",    bus.result,        '0);
    check("rst_zero",      W'(bus.zero),      W'(1));
    check("rst_overflow",  W'(bus.overflow),  W'(0));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_hi",        bus.hi,            '0);
    check("rst_lo",        bus.lo,            '0);
    check("rst_in_ready",  W'(bus.in_ready),  W'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle ops, issued back to back.
    issue(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1, 1);
    issue(OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1, 1);
    issue(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 1);
    issue(OP_AND,  32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1, 1);
    issue(OP_OR,   32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 1, 1);
    issue(OP_XOR,  32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, 1, 1);
    issue(OP_NOR,  32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 1'b0, 1, 1);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 1);
    issue(OP_SLL,  32'h00000001, 32'h0000002F, 32'h00008000, 1'b0, 1, 1);
    issue(OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1, 1);
    issue(OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1, 1);
    issue(OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1, 1);
    issue(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 1);
    idle();
    drain();

    // MULT -3 * 7: busy for W cycles, hi/lo untouched until completion.
    old_hi = m_hi;
    old_lo = m_lo;
    m_hi   = 32'hFFFFFFFF;
    m_lo   = 32'hFFFFFFEB;
    issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0, W + 1, 1);
    idle();
    busy_ready = 0;
    busy_hilo  = 0;
    for (int i = 0; i < W; i++) begin
      if (bus.in_ready) busy_ready++;
      if (bus.hi !== old_hi || bus.lo !== old_lo) busy_hilo++;
      @(negedge clk);
    end
    check("mult_in_ready_low_cycles", W'(busy_ready), W'(0));
    check("mult_hilo_stable_cycles",  W'(busy_hilo),  W'(0));
    check("mult_in_ready_after",      W'(bus.in_ready), W'(1));

    issue(OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1, 1);
    issue(OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFEB, 1'b0, 1, 1);

    // MULTU stays requested while busy; only the following ADD may be accepted next.
    m_hi = 32'h00000001;
    m_lo = 32'hFFFFFFFE;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, W + 1, 1);
    issue(OP_ADD,   32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1, 1);
    idle();
    drain();

`ifdef SEQ_ALU_DIV_EN
    m_hi = 32'hFFFFFFFF;
    m_lo = 32'hFFFFFFFD;
    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, W + 2, 1);
    m_hi = 32'h00001234;
    m_lo = 32'hFFFFFFFF;
    issue(OP_DIV, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b0, W + 2, 1);
    m_hi = 32'h00000000;
    m_lo = 32'h80000000;
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, W + 2, 1);
`else
    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 1'b1, 1, 1);
`endif
    idle();
    drain();

    // Reset ten cycles into a MULT: no result, hi/lo cleared, ready right after release.
    issue(OP_MULT, 32'h00000005, 32'h00000006, 32'h0, 1'b0, 0, 0);
    idle();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_in_rst", W'(bus.in_ready), W'(0));
    rst = 1'b0;
    #1;
    check("midrst_hi",        bus.hi,            '0);
    check("midrst_lo",        bus.lo,            '0);
    check("midrst_out_valid", W'(bus.out_valid), W'(0));
    check("midrst_in_ready",  W'(bus.in_ready),  W'(1));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    repeat (W + 4) @(negedge clk);
    issue(OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1, 1);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
